// File: rtl/lights_fsm.sv
// lights_fsm: free-running GREEN -> YELLOW -> RED controller, per-state dwell.
// Ports: clk, reset (async, active-low), light_out[1:0] (00 G, 01 Y, 10 R).
module lights_fsm #(
  parameter int GREEN_CYCLES  = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int RED_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] light_out
);

  localparam int MAX_GY = (GREEN_CYCLES > YELLOW_CYCLES) ?
                          GREEN_CYCLES : YELLOW_CYCLES;
  localparam int MAX_D  = (MAX_GY > RED_CYCLES) ? MAX_GY : RED_CYCLES;
  localparam int CW     = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  localparam logic [CW-1:0] G_LAST = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RED_CYCLES - 1);

  if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 || RED_CYCLES < 1)
  begin : g_bad_param
    $error("lights_fsm: every dwell parameter must be >= 1");
  end

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } state_e;

  // Kept as a raw 2-bit register so the unused code 2'b11
  // (upset or forced) is representable and recoverable.
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;
  logic [1:0]    nxt;
  logic          legal;

  always_comb begin
    last  = '0;
    nxt   = GREEN;
    legal = 1'b1;
    case (state_q)
      GREEN: begin
        last = G_LAST;
        nxt  = YELLOW;
      end
      YELLOW: begin
        last = Y_LAST;
        nxt  = RED;
      end
      RED: begin
        last = R_LAST;
        nxt  = GREEN;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = GREEN;
    cnt_d   = '0;
    if (!legal) begin
      state_d = GREEN;
      cnt_d   = '0;
    end else if (cnt_q == last) begin
      state_d = nxt;
      cnt_d   = '0;
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GREEN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign light_out = state_q;

endmodule

// File: tb/tb_lights_fsm.sv
// tb_lights_fsm: self-checking bench for lights_fsm (default and 1/1/1 dwell).
// Expected lights come from edge counts since reset, reduced modulo the period.
module tb_lights_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] light_out;
  logic [1:0] light_out1;

  int checks = 0;
  int errors = 0;
  int k  = 0;
  int k1 = 0;

  lights_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .light_out (light_out)
  );

  lights_fsm #(
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .RED_CYCLES    (1)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .light_out (light_out1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] exp_light(int n, int g, int y, int r);
    int p;
    p = n % (g + y + r);
    if (p < g) return 2'b00;
    if (p < g + y) return 2'b01;
    return 2'b10;
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp,
             $time);
    end
  endtask

  task automatic check_both(string tag);
    chk({tag, "_def"}, light_out, exp_light(k, 4, 2, 4));
    chk({tag, "_one"}, light_out1, exp_light(k1, 1, 1, 1));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    if (reset) begin
      k++;
      k1++;
    end
    #1;
    check_both(tag);
  endtask

  task automatic run(int n, string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Reset pulse starting between edges; hold spans extra checked edges.
  task automatic pulse(int hold, string tag);
    #($urandom_range(1, 3));
    reset = 1'b0;
    k  = 0;
    k1 = 0;
    #1;
    check_both({tag, "_async"});
    for (int i = 0; i < hold; i++) tick({tag, "_held"});
    @(negedge clk);
    #($urandom_range(0, 3));
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    #2;
    check_both("por");
    run(5, "por_hold");
    @(negedge clk);
    reset = 1'b1;

    run(20, "two_periods");

    run(7, "to_red2");
    pulse(0, "red_rst");
    run(10, "after_red_rst");

    run(5, "to_yellow");
    pulse(0, "yel_rst");
    run(10, "after_yel_rst");

    run(3, "pre_force");
    #2;
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    #1;
    chk("illegal_visible", light_out, 2'b11);
    k = -1;
    tick("illegal_recover");
    run(12, "after_illegal");

    for (int it = 0; it < 8; it++) begin
      run(int'($urandom_range(1, 23)), "rand_run");
      pulse(int'($urandom_range(0, 3)), "rand_rst");
    end
    run(10, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
